alu_req_arbiter: RTL

- Shares the single sequential ALU (add/sub/Booth multiply/non-restoring divide, start/finish handshake) between two requesters.
- Arbitrates round-robin between the requesters and latches the winner's opcode and operands.
- Sequences the ALU start/finish handshake and returns the 2W-bit result to the winning requester with a one-cycle ack.
- Handles divide-by-zero and a hung ALU (timeout) itself, without blocking the other requester.

---
 rtl/alu_req_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/alu_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_req_arbiter
//  Description : Shares one sequential ALU (start/finish handshake) between
//                two requesters. Round-robin arbitration, operand latching,
//                divide-by-zero short-circuit and WAIT timeout handling.
//  Ports       : clk, rst_b (async, active-high)
//                req0/1, op0/1, x0/y0, x1/y1   - requester inputs
//                ack0/1, res0/1, err0/1        - per-requester responses
//                alu_start, alu_s, alu_x, alu_y, alu_finish, alu_res - ALU side
//                busy, owner                   - status
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_req_arbiter #(
    parameter int W       = 8,
    parameter int TIMEOUT = 63
) (
    input  logic           clk,
    input  logic           rst_b,
    input  logic           req0,
    input  logic           req1,
    input  logic [1:0]     op0,
    input  logic [1:0]     op1,
    input  logic [W-1:0]   x0,
    input  logic [W-1:0]   y0,
    input  logic [W-1:0]   x1,
    input  logic [W-1:0]   y1,
    output logic           ack0,
    output logic           ack1,
    output logic [2*W-1:0] res0,
    output logic [2*W-1:0] res1,
    output logic           err0,
    output logic           err1,
    output logic           alu_start,
    output logic [1:0]     alu_s,
    output logic [W-1:0]   alu_x,
    output logic [W-1:0]   alu_y,
    input  logic           alu_finish,
    input  logic [2*W-1:0] alu_res,
    output logic           busy,
    output logic           owner
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [1:0] C_OP_DIV  = 2'b11;
    // Counter value in the last permitted WAIT cycle (counter counts from 0).
    localparam logic [7:0] C_TO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]     r_state;
    logic [1:0]     w_next;
    logic           r_ptr;
    logic [7:0]     r_cnt;

    logic           w_grant_vld;
    logic           w_gnt;
    logic [1:0]     w_op;
    logic [W-1:0]   w_x;
    logic [W-1:0]   w_y;
    logic           w_div0;
    logic           w_timeout;
    logic           w_ld_en;
    logic           w_ld_port;
    logic [2*W-1:0] w_ld_res;
    logic           w_ld_err;

    // Arbitration: a lone request wins outright, a tie goes to the pointer.
    assign w_grant_vld = req0 | req1;
    assign w_gnt       = (req0 & req1) ? r_ptr : req1;
    assign w_op        = w_gnt ? op1 : op0;
    assign w_x         = w_gnt ? x1  : x0;
    assign w_y         = w_gnt ? y1  : y0;
    assign w_div0      = (w_op == C_OP_DIV) && (w_y == '0);
    assign w_timeout   = (r_cnt == C_TO_LAST);

    // Result/error load happens on the transition into RESP. In IDLE the
    // owner register is not yet updated, so the fresh grant index is used.
    always_comb begin
        w_ld_en   = 1'b0;
        w_ld_port = owner;
        w_ld_res  = '0;
        w_ld_err  = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_ld_port = w_gnt;
                w_ld_en   = w_grant_vld && w_div0;
            end
            S_WAIT: begin
                // Finish takes priority over a coincident timeout.
                if (alu_finish) begin
                    w_ld_en  = 1'b1;
                    w_ld_res = alu_res;
                    w_ld_err = 1'b0;
                end else begin
                    w_ld_en  = w_timeout;
                end
            end
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_vld) begin
                    w_next = w_div0 ? S_RESP : S_START;
                end
            end
            S_START: w_next = S_WAIT;
            S_WAIT: begin
                if (alu_finish || w_timeout) begin
                    w_next = S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Moore output decodes
    always_comb begin
        alu_start = (r_state == S_START);
        busy      = (r_state != S_IDLE);
        ack0      = (r_state == S_RESP) && (owner == 1'b0);
        ack1      = (r_state == S_RESP) && (owner == 1'b1);
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            r_ptr <= 1'b0;
            r_cnt <= '0;
            owner <= 1'b0;
            alu_s <= '0;
            alu_x <= '0;
            alu_y <= '0;
            res0  <= '0;
            res1  <= '0;
            err0  <= 1'b0;
            err1  <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && w_grant_vld) begin
                alu_s <= w_op;
                alu_x <= w_x;
                alu_y <= w_y;
                owner <= w_gnt;
                r_ptr <= ~w_gnt;
            end
            if (r_state == S_START) begin
                r_cnt <= '0;
            end else if ((r_state == S_WAIT) && !alu_finish && !w_timeout) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_ld_en) begin
                if (w_ld_port) begin
                    res1 <= w_ld_res;
                    err1 <= w_ld_err;
                end else begin
                    res0 <= w_ld_res;
                    err0 <= w_ld_err;
                end
            end
        end
    end

endmodule
`default_nettype wire
